out_fifo_8x4: RTL and testbench
===============================

Name: out_fifo_8x4

Overview:
- Transmit-direction companion to the 4-to-8 input FIFO; this block is the 8-to-4 output FIFO.
- The fabric writes 10 byte-wide channels per entry. The block drains them to the I/O side as 10 nibble-wide channels: low nibble first, then high nibble.
- Single-clock behavioural model with the status-flag semantics of the input FIFO: EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL.
- Sits between the fabric datapath and the output serializers.

Parameters:
- ALMOST_EMPTY_VALUE, 1, almost-empty offset in nibbles (legal 1-2).
- ALMOST_FULL_VALUE, 1, almost-full offset in entries (legal 1-2).
- DEPTH, 8, storage entries (power of 2, at least 4).

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- WREN  in  1  write enable, pushes one 80-bit entry.
- D  in  80  channel n byte at D[8n+7:8n], n = 0..9.
- RDEN  in  1  read enable, pops one nibble slice.
- Q  out  40  channel n nibble at Q[4n+3:4n], registered.
- EMPTY  out  1  no nibble available.
- FULL  out  1  no free entry.
- ALMOSTEMPTY  out  1  nibble count <= ALMOST_EMPTY_VALUE.
- ALMOSTFULL  out  1  free entries <= ALMOST_FULL_VALUE.

Behaviour:
- Reset (RESET_N = 0 at a clock edge):
  - wr_ptr, rd_ptr, nib_sel and count clear to 0.
  - Q = 0, EMPTY = 1, FULL = 0, ALMOSTEMPTY = 1, ALMOSTFULL = 0.
  - Storage contents are not cleared.
  - Reset mid-operation discards all data and overrides WREN/RDEN in the same cycle.
- Occupancy:
  - count is held in nibble slices, 0..2*DEPTH, width clog2(2*DEPTH)+1.
  - Free entries = DEPTH - ceil(count/2).
  - A half-drained entry (nib_sel = 1) still occupies its slot.
- Accepted write = WREN && !FULL:
  - mem[wr_ptr] <= D; wr_ptr increments modulo DEPTH; count += 2.
- Accepted read = RDEN && !EMPTY:
  - Q <= nib_sel ? high nibbles of mem[rd_ptr] : low nibbles; all channels use the same nib_sel.
  - nib_sel toggles; when nib_sel was 1, rd_ptr increments modulo DEPTH.
  - count -= 1.
  - Read latency: 1 cycle, Q valid the cycle after RDEN is sampled.
- Simultaneous accepted write and read: count += 1 net. The read cannot return the same-cycle write; there is no bypass.
- Write while FULL: ignored even if a read is accepted the same cycle, because flags use registered state. Pointers, memory and count are unchanged.
- Read while EMPTY: ignored; Q holds its last value.
- Flag timing: all flags are registered from the next-state count, so they are valid the cycle after the causing edge with no extra lag.
  - FULL = (free entries == 0).
  - EMPTY = (count == 0).
- Wrap-around: pointers wrap DEPTH-1 to 0 without a bubble; full vs empty is decided by count, not by pointer equality.
- Maximum throughput: one write every 2 cycles against continuous reads.

Optional Feature:
- Macro: OUT_FIFO_ERR_FLAG_EN.
- Defined:
  - Adds outputs OVERFLOW (1) and UNDERFLOW (1), both sticky.
  - OVERFLOW sets the cycle after WREN is sampled with FULL = 1.
  - UNDERFLOW sets the cycle after RDEN is sampled with EMPTY = 1.
  - Both clear only on reset, to 0.
- Undefined: the ports and their logic are absent; illegal accesses are silently ignored as described above.

Decomposition:
- Package out_fifo_pkg holds:
  - NUM_CH = 10, BYTE_W = 8, NIB_W = 4;
  - D_W = NUM_CH*BYTE_W and Q_W = NUM_CH*NIB_W;
  - function clog2.
- One sub-module, out_fifo_flags: combinational next-flag logic from next count and the parameters. The top level registers its outputs.
- Storage, pointers and nibble mux stay in out_fifo_8x4.

Test Plan:
- Reset then idle: EMPTY = 1, ALMOSTEMPTY = 1, FULL = 0, ALMOSTFULL = 0, Q = 0. RDEN pulses leave Q at 0.
- Single entry: write D with every byte = 0xA5, then RDEN for 2 cycles.
  - Q = all 5s, then all As.
  - EMPTY goes 0 after the write and 1 after the second read.
- Fill: 8 writes with byte value = index.
  - ALMOSTFULL asserts after write 7; FULL after write 8.
  - A 9th write with 0xFF is ignored.
  - Draining 16 nibbles returns 0,0,1,0,...,7,0 per channel; the 0xFF nibbles never appear.
- Wrap and concurrency: continuous reads with writes every 2 cycles for 40 entries of incrementing data.
  - Output stream is in order, with no FULL and no EMPTY after the first write.
- Reset mid-stream with 5 entries queued: RESET_N low for 1 cycle.
  - Flags return to reset values and Q = 0 on the next cycle.
  - A subsequent read-after-write returns the new data only.
- With OUT_FIFO_ERR_FLAG_EN: write while FULL, then read while EMPTY.
  - OVERFLOW asserts, then UNDERFLOW asserts.
  - Both stay 1 until RESET_N = 0.

Source files
------------

// File: rtl/out_fifo_pkg.sv
// rtl/out_fifo_pkg.sv - shared widths and helpers for the 8-to-4 output FIFO
package out_fifo_pkg;

  localparam int NUM_CH = 10;
  localparam int BYTE_W = 8;
  localparam int NIB_W  = 4;
  localparam int D_W    = NUM_CH * BYTE_W;
  localparam int Q_W    = NUM_CH * NIB_W;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/out_fifo_flags.sv
// rtl/out_fifo_flags.sv - next-state status flags from the next nibble count
module out_fifo_flags
  import out_fifo_pkg::*;
#(
  parameter int DEPTH              = 8,
  parameter int ALMOST_EMPTY_VALUE = 1,
  parameter int ALMOST_FULL_VALUE  = 1,
  parameter int CNT_W              = clog2(2 * DEPTH) + 1
) (
  input  logic [CNT_W-1:0] count_i,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_empty_o,
  output logic             almost_full_o
);

  logic [CNT_W-1:0] used_entries;
  logic [CNT_W-1:0] free_entries;

  // A half-drained entry still holds its slot, hence the round-up.
  always_comb begin
    used_entries   = (count_i + CNT_W'(1)) >> 1;
    free_entries   = CNT_W'(DEPTH) - used_entries;
    empty_o        = (count_i == '0);
    full_o         = (free_entries == '0);
    almost_empty_o = (count_i <= CNT_W'(ALMOST_EMPTY_VALUE));
    almost_full_o  = (free_entries <= CNT_W'(ALMOST_FULL_VALUE));
  end

endmodule

// File: rtl/out_fifo_8x4.sv
// rtl/out_fifo_8x4.sv - byte-wide write, nibble-wide read FIFO for 10 channels
// Optional sticky OVERFLOW/UNDERFLOW outputs with OUT_FIFO_ERR_FLAG_EN.
module out_fifo_8x4
  import out_fifo_pkg::*;
#(
  parameter int ALMOST_EMPTY_VALUE = 1,
  parameter int ALMOST_FULL_VALUE  = 1,
  parameter int DEPTH              = 8
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic           WREN,
  input  logic [D_W-1:0] D,
  input  logic           RDEN,
  output logic [Q_W-1:0] Q,
  output logic           EMPTY,
  output logic           FULL,
  output logic           ALMOSTEMPTY,
  output logic           ALMOSTFULL
`ifdef OUT_FIFO_ERR_FLAG_EN
  ,
  output logic           OVERFLOW,
  output logic           UNDERFLOW
`endif
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(2 * DEPTH) + 1;

  logic [D_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             nib_sel_q, nib_sel_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [Q_W-1:0]   q_q, q_d;
  logic             empty_q, full_q, aempty_q, afull_q;
  logic             empty_d, full_d, aempty_d, afull_d;
  logic             wr_acc, rd_acc;
  logic [D_W-1:0]   rd_entry;

  // Acceptance uses registered flags only, so a same-cycle read never frees room for a write.
  always_comb begin
    wr_acc    = WREN && !full_q;
    rd_acc    = RDEN && !empty_q;
    rd_entry  = mem_q[rd_ptr_q];
    wr_ptr_d  = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = (rd_acc && nib_sel_q) ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    nib_sel_d = rd_acc ? ~nib_sel_q : nib_sel_q;
    count_d   = count_q + (wr_acc ? CNT_W'(2) : CNT_W'(0)) - (rd_acc ? CNT_W'(1) : CNT_W'(0));
    q_d       = q_q;
    if (rd_acc) begin
      for (int n = 0; n < NUM_CH; n++) begin
        q_d[n*NIB_W +: NIB_W] = nib_sel_q ? rd_entry[n*BYTE_W+NIB_W +: NIB_W]
                                          : rd_entry[n*BYTE_W +: NIB_W];
      end
    end
  end

  out_fifo_flags #(
    .DEPTH              (DEPTH),
    .ALMOST_EMPTY_VALUE (ALMOST_EMPTY_VALUE),
    .ALMOST_FULL_VALUE  (ALMOST_FULL_VALUE),
    .CNT_W              (CNT_W)
  ) u_flags (
    .count_i        (count_d),
    .empty_o        (empty_d),
    .full_o         (full_d),
    .almost_empty_o (aempty_d),
    .almost_full_o  (afull_d)
  );

  always_ff @(posedge CLK) begin
    if (RESET_N && wr_acc) mem_q[wr_ptr_q] <= D;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      nib_sel_q <= 1'b0;
      count_q   <= '0;
      q_q       <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      aempty_q  <= 1'b1;
      afull_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      nib_sel_q <= nib_sel_d;
      count_q   <= count_d;
      q_q       <= q_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      aempty_q  <= aempty_d;
      afull_q   <= afull_d;
    end
  end

  assign Q           = q_q;
  assign EMPTY       = empty_q;
  assign FULL        = full_q;
  assign ALMOSTEMPTY = aempty_q;
  assign ALMOSTFULL  = afull_q;

`ifdef OUT_FIFO_ERR_FLAG_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (WREN && full_q)  overflow_q  <= 1'b1;
      if (RDEN && empty_q) underflow_q <= 1'b1;
    end
  end

  assign OVERFLOW  = overflow_q;
  assign UNDERFLOW = underflow_q;
`endif

endmodule

// File: tb/tb_out_fifo_8x4.sv
// tb/tb_out_fifo_8x4.sv - queue-model and directed-vector bench for out_fifo_8x4
module tb_out_fifo_8x4;
  import out_fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int AEV   = 1;
  localparam int AFV   = 1;

  logic           CLK = 1'b0;
  logic           RESET_N, WREN, RDEN;
  logic [D_W-1:0] D;
  logic [Q_W-1:0] Q;
  logic           EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL;
`ifdef OUT_FIFO_ERR_FLAG_EN
  logic           OVERFLOW, UNDERFLOW;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [Q_W-1:0] mq[$];
  logic [Q_W-1:0] m_q;
  bit             m_ovf, m_udf, m_full_now, m_empty_now;
  bit             saw_bad_flag;

  always #5 CLK = ~CLK;

  out_fifo_8x4 #(
    .ALMOST_EMPTY_VALUE (AEV),
    .ALMOST_FULL_VALUE  (AFV),
    .DEPTH              (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .WREN        (WREN),
    .D           (D),
    .RDEN        (RDEN),
    .Q           (Q),
    .EMPTY       (EMPTY),
    .FULL        (FULL),
    .ALMOSTEMPTY (ALMOSTEMPTY),
    .ALMOSTFULL  (ALMOSTFULL)
`ifdef OUT_FIFO_ERR_FLAG_EN
    ,
    .OVERFLOW    (OVERFLOW),
    .UNDERFLOW   (UNDERFLOW)
`endif
  );

  function automatic logic [Q_W-1:0] slice(input logic [D_W-1:0] d, input bit hi);
    logic [Q_W-1:0] s;
    for (int n = 0; n < NUM_CH; n++) s[n*4 +: 4] = hi ? d[n*8+4 +: 4] : d[n*8 +: 4];
    return s;
  endfunction

  function automatic int free_of(input int c);
    return DEPTH - (c + 1) / 2;
  endfunction

  function automatic logic [D_W-1:0] make_d(input int e);
    logic [D_W-1:0] d;
    for (int n = 0; n < NUM_CH; n++) d[n*8 +: 8] = 8'(e + n * 16);
    return d;
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string nm, input logic [Q_W-1:0] act, input logic [Q_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit w, input bit r, input logic [D_W-1:0] d);
    WREN = w;
    RDEN = r;
    D    = d;
    @(negedge CLK);
  endtask

  // Model: a queue of nibble slices; flags follow directly from its length.
  always @(posedge CLK) begin
    if (!RESET_N) begin
      mq.delete();
      m_q   = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_empty_now = (mq.size() == 0);
      m_full_now  = (free_of(mq.size()) == 0);
      if (WREN && m_full_now)  m_ovf = 1'b1;
      if (RDEN && m_empty_now) m_udf = 1'b1;
      if (RDEN && !m_empty_now) m_q = mq.pop_front();
      if (WREN && !m_full_now) begin
        mq.push_back(slice(D, 1'b0));
        mq.push_back(slice(D, 1'b1));
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk_q  ("cyc_q",      Q,           m_q);
      chk_bit("cyc_empty",  EMPTY,       mq.size() == 0);
      chk_bit("cyc_full",   FULL,        free_of(mq.size()) == 0);
      chk_bit("cyc_aempty", ALMOSTEMPTY, mq.size() <= AEV);
      chk_bit("cyc_afull",  ALMOSTFULL,  free_of(mq.size()) <= AFV);
`ifdef OUT_FIFO_ERR_FLAG_EN
      chk_bit("cyc_ovf",    OVERFLOW,    m_ovf);
      chk_bit("cyc_udf",    UNDERFLOW,   m_udf);
`endif
    end
  end

  initial begin
    logic [3:0] nib;
    RESET_N = 1'b0;
    WREN    = 1'b0;
    RDEN    = 1'b0;
    D       = '0;
    repeat (2) @(negedge CLK);
    chk_en = 1'b1;
    chk_bit("rst_empty",  EMPTY,       1'b1);
    chk_bit("rst_aempty", ALMOSTEMPTY, 1'b1);
    chk_bit("rst_full",   FULL,        1'b0);
    chk_bit("rst_afull",  ALMOSTFULL,  1'b0);
    chk_q  ("rst_q",      Q,           '0);
    RESET_N = 1'b1;

    step(0, 1, '0);
    step(0, 1, '0);
    chk_q("idle_rd_q", Q, '0);

    step(1, 0, {NUM_CH{8'hA5}});
    chk_bit("one_empty_wr", EMPTY, 1'b0);
    step(0, 1, '0);
    chk_q("one_lo", Q, {NUM_CH{4'h5}});
    step(0, 1, '0);
    chk_q("one_hi", Q, {NUM_CH{4'hA}});
    chk_bit("one_empty_rd", EMPTY, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, {NUM_CH{8'(i)}});
      if (i == 5) chk_bit("fill_af6", ALMOSTFULL, 1'b0);
      if (i == 6) begin
        chk_bit("fill_af7",   ALMOSTFULL, 1'b1);
        chk_bit("fill_full7", FULL,       1'b0);
      end
      if (i == 7) chk_bit("fill_full8", FULL, 1'b1);
    end
    step(1, 0, {NUM_CH{8'hFF}});
    chk_bit("fill_full9", FULL, 1'b1);
`ifdef OUT_FIFO_ERR_FLAG_EN
    chk_bit("err_ovf_set", OVERFLOW, 1'b1);
`endif
    for (int k = 0; k < 2 * DEPTH; k++) begin
      step(0, 1, '0);
      nib = (k % 2 == 0) ? 4'(k / 2) : 4'h0;
      chk_q("fill_drain", Q, {NUM_CH{nib}});
    end
    chk_bit("fill_empty", EMPTY, 1'b1);

    saw_bad_flag = 1'b0;
    for (int c = 0; c < 80; c++) begin
      step(c % 2 == 0, c > 0, make_d(c / 2));
      if (EMPTY || FULL) saw_bad_flag = 1'b1;
    end
    chk_bit("stream_flags", saw_bad_flag, 1'b0);
    step(0, 1, '0);
    chk_q("stream_last", Q, slice(make_d(39), 1'b1));
    chk_bit("stream_empty", EMPTY, 1'b1);

    step(0, 1, '0);
`ifdef OUT_FIFO_ERR_FLAG_EN
    chk_bit("err_udf_set", UNDERFLOW, 1'b1);
    step(0, 0, '0);
    step(0, 0, '0);
    chk_bit("err_ovf_hold", OVERFLOW,  1'b1);
    chk_bit("err_udf_hold", UNDERFLOW, 1'b1);
`endif

    for (int i = 0; i < 5; i++) step(1, 0, make_d(100 + i));
    RESET_N = 1'b0;
    step(1, 1, make_d(7));
    RESET_N = 1'b1;
    chk_bit("mid_empty",  EMPTY,       1'b1);
    chk_bit("mid_aempty", ALMOSTEMPTY, 1'b1);
    chk_bit("mid_full",   FULL,        1'b0);
    chk_bit("mid_afull",  ALMOSTFULL,  1'b0);
    chk_q  ("mid_q",      Q,           '0);
`ifdef OUT_FIFO_ERR_FLAG_EN
    chk_bit("mid_ovf", OVERFLOW,  1'b0);
    chk_bit("mid_udf", UNDERFLOW, 1'b0);
`endif
    step(1, 0, {NUM_CH{8'h3C}});
    step(0, 1, '0);
    chk_q("post_lo", Q, {NUM_CH{4'hC}});
    step(0, 1, '0);
    chk_q("post_hi", Q, {NUM_CH{4'h3}});
    chk_bit("post_empty", EMPTY, 1'b1);
    step(0, 0, '0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
